// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the fetch front-end: default widths, the NOP used as the
// reset instruction, fetch FSM state encodings and the PC next-value select.
package instruction_fetch_unit_pkg;

  localparam int unsigned WORDSIZE_DEFAULT         = 32'd64;
  localparam int unsigned INSTRUCTION_SIZE_DEFAULT = 32'd32;

  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_ERROR = 3'd5
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_INCR     = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_e;

  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_program_counter.sv
// Program counter register with hold / fetch_pc+4 / redirect select, plus the
// word-alignment check applied to the redirect target.
module program_counter
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned          WORDSIZE = 32'd64,
  parameter logic [WORDSIZE-1:0]  RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  pc_sel_e             pc_sel,
  input  logic [WORDSIZE-1:0] fetch_pc,
  input  logic [WORDSIZE-1:0] redirect_pc,
  output logic [WORDSIZE-1:0] pc,
  output logic                redirect_aligned
);

  logic [WORDSIZE-1:0] pc_d;
  logic [WORDSIZE-1:0] pc_q;

  // next-pc select; the increment wraps modulo 2^WORDSIZE
  always_comb begin
    pc_d = pc_q;
    case (pc_sel)
      PC_HOLD:     pc_d = pc_q;
      PC_INCR:     pc_d = fetch_pc + WORDSIZE'(3'd4);
      PC_REDIRECT: pc_d = redirect_pc;
      default:     pc_d = pc_q;
    endcase
  end

  // pc register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc               = pc_q;
  assign redirect_aligned = is_word_aligned(redirect_pc[1:0]);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front-end: single outstanding imem request, instruction
// register held across decode stalls, redirect with in-flight discard, sticky misalignment error.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned          WORDSIZE         = WORDSIZE_DEFAULT,
  parameter int unsigned          INSTRUCTION_SIZE = INSTRUCTION_SIZE_DEFAULT,
  parameter logic [WORDSIZE-1:0]  RESET_PC         = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        if_imem_req_valid,
  input  logic                        if_imem_req_ready,
  output logic [WORDSIZE-1:0]         if_imem_addr,
  input  logic                        if_imem_rsp_valid,
  input  logic [INSTRUCTION_SIZE-1:0] if_imem_rsp_data,
  input  logic                        if_redirect_en,
  input  logic [WORDSIZE-1:0]         if_redirect_pc,
  input  logic                        if_stall,
  output logic [INSTRUCTION_SIZE-1:0] if_instruction,
  output logic [WORDSIZE-1:0]         if_pc,
  output logic                        if_instr_valid,
  output logic                        if_misaligned
);

  localparam logic [INSTRUCTION_SIZE-1:0] RESET_INSTR = INSTRUCTION_SIZE'(NOP_INSTRUCTION);

  fetch_state_e                state_d,       state_q;
  logic [WORDSIZE-1:0]         fetch_pc_d,    fetch_pc_q;
  logic [INSTRUCTION_SIZE-1:0] instr_d,       instr_q;
  logic [WORDSIZE-1:0]         instr_pc_d,    instr_pc_q;
  logic                        instr_valid_d, instr_valid_q;
  logic                        misaligned_d,  misaligned_q;
  logic                        req_valid_d,   req_valid_q;

  pc_sel_e             pc_sel_s;
  logic [WORDSIZE-1:0] pc_s;
  logic                redirect_aligned_s;

  program_counter #(
    .WORDSIZE (WORDSIZE),
    .RESET_PC (RESET_PC)
  ) u_program_counter (
    .clk              (clk),
    .rst_n            (rst_n),
    .pc_sel           (pc_sel_s),
    .fetch_pc         (fetch_pc_q),
    .redirect_pc      (if_redirect_pc),
    .pc               (pc_s),
    .redirect_aligned (redirect_aligned_s)
  );

  // next-state and datapath control; redirect overrides every arc except ERROR
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    misaligned_d  = misaligned_q;
    pc_sel_s      = PC_HOLD;

    case (state_q)
      ST_ERROR: begin
        state_d       = ST_ERROR;
        instr_valid_d = 1'b0;
        misaligned_d  = 1'b1;
      end
      default: begin
        if (if_redirect_en) begin
          if (!redirect_aligned_s) begin
            state_d       = ST_ERROR;
            instr_valid_d = 1'b0;
            misaligned_d  = 1'b1;
          end else begin
            pc_sel_s      = PC_REDIRECT;
            instr_valid_d = 1'b0;
            // an accepted-but-unanswered request must be drained before refetching
            case (state_q)
              ST_IDLE:  state_d = ST_FETCH;
              ST_FETCH: state_d = if_imem_req_ready ? ST_DRAIN : ST_FETCH;
              ST_WAIT:  state_d = if_imem_rsp_valid ? ST_FETCH : ST_DRAIN;
              ST_HOLD:  state_d = ST_FETCH;
              ST_DRAIN: state_d = ST_DRAIN;
              default:  state_d = ST_FETCH;
            endcase
          end
        end else begin
          case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
              if (if_imem_req_ready) begin
                fetch_pc_d = pc_s;
                state_d    = ST_WAIT;
              end else begin
                state_d    = ST_FETCH;
              end
            end
            ST_WAIT: begin
              if (if_imem_rsp_valid) begin
                instr_d       = if_imem_rsp_data;
                instr_pc_d    = fetch_pc_q;
                instr_valid_d = 1'b1;
                pc_sel_s      = PC_INCR;
                state_d       = ST_HOLD;
              end else begin
                state_d       = ST_WAIT;
              end
            end
            ST_HOLD: begin
              if (!if_stall) begin
                instr_valid_d = 1'b0;
                state_d       = ST_FETCH;
              end else begin
                state_d       = ST_HOLD;
              end
            end
            ST_DRAIN: begin
              if (if_imem_rsp_valid) begin
                state_d = ST_FETCH;
              end else begin
                state_d = ST_DRAIN;
              end
            end
            default: begin
              instr_valid_d = 1'b0;
              state_d       = ST_IDLE;
            end
          endcase
        end
      end
    endcase

    req_valid_d = (state_d == ST_FETCH);
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      fetch_pc_q    <= RESET_PC;
      instr_q       <= RESET_INSTR;
      instr_pc_q    <= RESET_PC;
      instr_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
      req_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      misaligned_q  <= misaligned_d;
      req_valid_q   <= req_valid_d;
    end
  end

  assign if_imem_req_valid = req_valid_q;
  assign if_imem_addr      = pc_s;
  assign if_instruction    = instr_q;
  assign if_pc             = instr_pc_q;
  assign if_instr_valid    = instr_valid_q;
  assign if_misaligned     = misaligned_q;

endmodule
